// File: rtl/muskbus_pkg.sv
// Shared Muskbus definitions: line/word widths, the write-arbiter state
// encoding and a small round-robin helper.
package muskbus_pkg;

    localparam int LINE_BITS = 512;
    localparam int WORD_BITS = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    // Next round-robin start position after index idx among n clients.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/muskbus_rr_picker.sv
// Combinational round-robin picker: returns the first set request bit found
// by searching upward from rr_ptr and wrapping to 0.
module muskbus_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan every position once, starting at rr_ptr; the first hit wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/muskbus_write_arbiter.sv
// Round-robin arbiter sharing one Muskbus line-writer between NUM_CLIENTS
// requesters. One 64-byte line write at a time: IDLE -> ISSUE -> WAIT.
// Optional build macro LATCH_DATA_EN: capture the winner's address/data on
// grant so the client may change them after seeing wr_reqcyc.
module muskbus_write_arbiter
    import muskbus_pkg::*;
#(
    parameter int  NUM_CLIENTS = 4,
    localparam int IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CLIENTS-1:0]               cli_req,
    input  logic [NUM_CLIENTS-1:0][WORD_BITS-1:0] cli_addr,
    input  logic [NUM_CLIENTS-1:0][0:LINE_BITS-1] cli_data,
    output logic [NUM_CLIENTS-1:0]               cli_respcyc,
    output logic                                 wr_reqcyc,
    output logic [WORD_BITS-1:0]                 wr_addr,
    output logic [0:LINE_BITS-1]                 wr_data,
    input  logic                                 wr_respcyc,
    output logic                                 busy,
    output logic [IDX_W-1:0]                     grant_idx
);

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_ff;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    muskbus_rr_picker #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (cli_req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    assign grant_idx = grant_ff;

    // Transaction sequencer; wr_reqcyc and busy are registered with the state.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_ff  <= '0;
            wr_reqcyc <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_ff  <= pick_idx;
                        wr_reqcyc <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wr_reqcyc <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (wr_respcyc) begin
                        rr_ptr <= IDX_W'(rr_next(int'(grant_ff), NUM_CLIENTS));
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    wr_reqcyc <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Route the writer's completion to the grantee in the same cycle; a
    // completion seen outside WAIT is ignored.
    always_comb begin
        cli_respcyc = '0;
        if (state == WAIT && wr_respcyc) begin
            cli_respcyc[grant_ff] = 1'b1;
        end
    end

`ifdef LATCH_DATA_EN
    logic [WORD_BITS-1:0] addr_q;
    logic [0:LINE_BITS-1] data_q;

    // Capture the winner's line on the edge that enters ISSUE.
    always_ff @(posedge clk) begin
        // NOTE: these are ordinary registers, not a memory array, so they
        // take a reset value like any other flop.
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (state == IDLE && pick_found) begin
            addr_q <= cli_addr[pick_idx];
            data_q <= cli_data[pick_idx];
        end
    end

    // Present the captured line while a transaction is open, zero in IDLE.
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        if (busy) begin
            wr_addr = addr_q;
            wr_data = data_q;
        end
    end
`else
    // Mux the grantee's line straight through while a transaction is open.
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        if (busy) begin
            wr_addr = cli_addr[grant_ff];
            wr_data = cli_data[grant_ff];
        end
    end
`endif

endmodule

// File: tb/tb_muskbus_write_arbiter.sv
// Self-checking bench for muskbus_write_arbiter. A transaction-level model of
// the arbiter and a fixed-latency writer model run alongside the DUT; every
// cycle all outputs are compared, and each scenario adds its own checks.
module tb_muskbus_write_arbiter;

    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int LINE  = 512;
    localparam logic [0:LINE-1] PAT_A = {16{32'hA5A5_0F0F}};
    localparam logic [0:LINE-1] PAT_B = {16{32'h5A5A_F0F0}};

    logic                        clk = 1'b0;
    logic                        reset;
    logic [N-1:0]                cli_req;
    logic [N-1:0][63:0]          cli_addr;
    logic [N-1:0][0:LINE-1]      cli_data;
    logic [N-1:0]                cli_respcyc;
    logic                        wr_reqcyc;
    logic [63:0]                 wr_addr;
    logic [0:LINE-1]             wr_data;
    logic                        wr_respcyc;
    logic                        busy;
    logic [IDX_W-1:0]            grant_idx;

    // Values applied to the DUT at the next falling edge.
    logic                        nx_reset;
    logic [N-1:0]                nx_req;
    logic [N-1:0][63:0]          nx_addr;
    logic [N-1:0][0:LINE-1]      nx_data;
    bit                          nx_spur;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Arbiter model: open transaction flag, first-cycle flag, grantee, pointer.
    bit               m_active = 0;
    bit               m_first  = 0;
    logic [IDX_W-1:0] m_grant  = '0;
    logic [IDX_W-1:0] m_ptr    = '0;
    logic [63:0]      m_addr   = '0;
    logic [0:LINE-1]  m_data   = '0;

    // Writer model: responds wr_lat cycles after the start strobe.
    int wr_cnt = -1;
    int wr_lat = 10;

    int grants[$];
    int issue_cyc[$];

    always #5 clk = ~clk;

    muskbus_write_arbiter #(.NUM_CLIENTS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .cli_req     (cli_req),
        .cli_addr    (cli_addr),
        .cli_data    (cli_data),
        .cli_respcyc (cli_respcyc),
        .wr_reqcyc   (wr_reqcyc),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_respcyc  (wr_respcyc),
        .busy        (busy),
        .grant_idx   (grant_idx)
    );

    function automatic logic [0:LINE-1] rand_line();
        logic [0:LINE-1] v;
        for (int i = 0; i < LINE / 32; i++) v = {v[32:LINE-1], 32'($urandom)};
        return v;
    endfunction

    // One clock cycle: apply inputs, compare all outputs with the model, then
    // advance the model across the coming rising edge.
    task automatic step();
        logic [N-1:0]     e_resp;
        logic             e_req;
        logic             e_busy;
        logic [63:0]      e_addr;
        logic [0:LINE-1]  e_data;
        logic [IDX_W-1:0] c;
        @(negedge clk);
        cyc++;
        reset    = nx_reset;
        cli_req  = nx_req;
        cli_addr = nx_addr;
        cli_data = nx_data;
        if (wr_cnt > 0) wr_cnt--;
        wr_respcyc = !nx_reset && ((wr_cnt == 0) || nx_spur);
        #1;
        e_busy = m_active;
        e_req  = m_active && m_first;
        e_resp = '0;
        if (m_active && !m_first && wr_respcyc) e_resp[m_grant] = 1'b1;
        e_addr = '0;
        e_data = '0;
        if (m_active) begin
`ifdef LATCH_DATA_EN
            e_addr = m_addr;
            e_data = m_data;
`else
            e_addr = cli_addr[m_grant];
            e_data = cli_data[m_grant];
`endif
        end
        tests_run++;
        if (busy !== e_busy) begin
            tests_failed++;
            $display("FAIL model_busy cyc=%0d got %b want %b", cyc, busy, e_busy);
        end
        tests_run++;
        if (wr_reqcyc !== e_req) begin
            tests_failed++;
            $display("FAIL model_wr_reqcyc cyc=%0d got %b want %b", cyc, wr_reqcyc, e_req);
        end
        tests_run++;
        if (grant_idx !== m_grant) begin
            tests_failed++;
            $display("FAIL model_grant_idx cyc=%0d got %0d want %0d", cyc, grant_idx, m_grant);
        end
        tests_run++;
        if (cli_respcyc !== e_resp) begin
            tests_failed++;
            $display("FAIL model_cli_respcyc cyc=%0d got %b want %b", cyc, cli_respcyc, e_resp);
        end
        tests_run++;
        if (wr_addr !== e_addr) begin
            tests_failed++;
            $display("FAIL model_wr_addr cyc=%0d got %h want %h", cyc, wr_addr, e_addr);
        end
        tests_run++;
        if (wr_data !== e_data) begin
            tests_failed++;
            $display("FAIL model_wr_data cyc=%0d got %h want %h", cyc, wr_data, e_data);
        end
        if (wr_reqcyc === 1'b1) begin
            grants.push_back(int'(grant_idx));
            issue_cyc.push_back(cyc);
        end
        if (reset) begin
            m_active = 0;
            m_first  = 0;
            m_grant  = '0;
            m_ptr    = '0;
            m_addr   = '0;
            m_data   = '0;
            wr_cnt   = -1;
        end else begin
            if (wr_cnt == 0) wr_cnt = -1;
            if (e_req) wr_cnt = wr_lat;
            if (!m_active) begin
                if (cli_req != '0) begin
                    // Nearest requester at or after the pointer, cyclically.
                    for (int k = N - 1; k >= 0; k--) begin
                        c = IDX_W'((int'(m_ptr) + k) % N);
                        if (cli_req[c]) m_grant = c;
                    end
                    m_active = 1;
                    m_first  = 1;
                    m_addr   = cli_addr[m_grant];
                    m_data   = cli_data[m_grant];
                end
            end else if (m_first) begin
                m_first = 0;
            end else if (wr_respcyc) begin
                m_active = 0;
                m_ptr    = IDX_W'((int'(m_grant) + 1) % N);
            end
        end
    endtask

    task automatic wait_issue(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (wr_reqcyc === 1'b1) seen = 1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL issue_timeout got no wr_reqcyc in %0d cycles want one", budget);
        end
    endtask

    task automatic wait_resp(input int budget, output int at);
        bit seen = 0;
        at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (cli_respcyc !== '0) begin
                seen = 1;
                at   = cyc;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL resp_timeout got no cli_respcyc in %0d cycles want one", budget);
        end
    endtask

    task automatic drain();
        int n = 0;
        nx_req  = '0;
        nx_spur = 0;
        while ((m_active || busy !== 1'b0) && n < 60) begin
            step();
            n++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_timeout busy got %b want 0", busy);
        end
    endtask

    task automatic do_reset();
        nx_reset = 1'b1;
        step();
        step();
        nx_reset = 1'b0;
        grants.delete();
        issue_cyc.delete();
    endtask

    task automatic test_reset();
        nx_reset = 1'b1;
        step();
        step();
        tests_run++;
        if (busy !== 1'b0 || wr_reqcyc !== 1'b0 || cli_respcyc !== '0 ||
            wr_addr !== '0 || wr_data !== '0 || grant_idx !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs got busy=%b req=%b resp=%b addr=%h gidx=%0d want all 0",
                     busy, wr_reqcyc, cli_respcyc, wr_addr, grant_idx);
        end
        nx_reset = 1'b0;
    endtask

    task automatic test_single();
        bit seen;
        int c0;
        int rc;
        do_reset();
        nx_addr[0] = 64'h1000;
        nx_data[0] = PAT_A;
        nx_req     = 4'b0001;
        wr_lat     = 10;
        wait_issue(5, seen);
        c0 = cyc;
        tests_run++;
        if (wr_addr !== 64'h1000) begin
            tests_failed++;
            $display("FAIL single_addr got %h want 1000", wr_addr);
        end
        tests_run++;
        if (wr_data !== PAT_A) begin
            tests_failed++;
            $display("FAIL single_data got %h want %h", wr_data, PAT_A);
        end
        wait_resp(40, rc);
        tests_run++;
        if (rc - c0 != 10) begin
            tests_failed++;
            $display("FAIL single_latency got %0d want 10", rc - c0);
        end
        tests_run++;
        if (cli_respcyc !== 4'b0001 || grant_idx !== 2'd0) begin
            tests_failed++;
            $display("FAIL single_resp got resp=%b gidx=%0d want resp=0001 gidx=0",
                     cli_respcyc, grant_idx);
        end
        // Pointer moved to 1, so client 1 beats client 0 now.
        nx_req = 4'b0011;
        wait_issue(5, seen);
        tests_run++;
        if (grant_idx !== 2'd1) begin
            tests_failed++;
            $display("FAIL single_rr_ptr got grant %0d want 1", grant_idx);
        end
        drain();
    endtask

    task automatic test_round_robin();
        int n = 0;
        int exp_g[5] = '{0, 1, 2, 3, 0};
        do_reset();
        wr_lat = 3;
        nx_req = 4'b1111;
        while (grants.size() < 5 && n < 100) begin
            step();
            n++;
        end
        tests_run++;
        if (grants.size() != 5) begin
            tests_failed++;
            $display("FAIL rr_count got %0d grants want 5", grants.size());
        end
        for (int k = 0; k < 5 && k < grants.size(); k++) begin
            tests_run++;
            if (grants[k] != exp_g[k]) begin
                tests_failed++;
                $display("FAIL rr_order[%0d] got %0d want %0d", k, grants[k], exp_g[k]);
            end
        end
        // Strobe, 3-cycle writer latency, one IDLE cycle, next strobe.
        for (int k = 1; k < issue_cyc.size(); k++) begin
            tests_run++;
            if (issue_cyc[k] - issue_cyc[k-1] != 5) begin
                tests_failed++;
                $display("FAIL rr_spacing[%0d] got %0d want 5", k, issue_cyc[k] - issue_cyc[k-1]);
            end
        end
        drain();
    endtask

    task automatic test_wrap();
        bit seen;
        int rc;
        int n = 0;
        do_reset();
        wr_lat = 2;
        nx_req = 4'b0100;
        wait_issue(5, seen);
        wait_resp(20, rc);
        // Pointer is now 3; client 3 is idle so the search wraps to 0.
        nx_req = 4'b0101;
        grants.delete();
        while (grants.size() < 2 && n < 40) begin
            step();
            n++;
        end
        tests_run++;
        if (grants.size() != 2 || grants[0] != 0 || grants[1] != 2) begin
            tests_failed++;
            $display("FAIL wrap_order got %p want '{0, 2}", grants);
        end
        drain();
    endtask

    task automatic test_drop_and_spurious();
        bit seen;
        int rc;
        do_reset();
        wr_lat = 5;
        nx_req = 4'b0010;
        wait_issue(5, seen);
        step();
        nx_req = 4'b0000;
        wait_resp(20, rc);
        tests_run++;
        if (cli_respcyc !== 4'b0010) begin
            tests_failed++;
            $display("FAIL drop_resp got %b want 0010", cli_respcyc);
        end
        step();
        nx_spur = 1;
        step();
        tests_run++;
        if (cli_respcyc !== '0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL spurious_idle got resp=%b busy=%b want 0000 0", cli_respcyc, busy);
        end
        nx_spur = 0;
        nx_req  = 4'b0001;
        step();
        nx_spur = 1;
        step();
        tests_run++;
        if (wr_reqcyc !== 1'b1 || cli_respcyc !== '0) begin
            tests_failed++;
            $display("FAIL spurious_issue got req=%b resp=%b want 1 0000", wr_reqcyc, cli_respcyc);
        end
        nx_spur = 0;
        wait_resp(20, rc);
        tests_run++;
        if (cli_respcyc !== 4'b0001) begin
            tests_failed++;
            $display("FAIL spurious_then_resp got %b want 0001", cli_respcyc);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bit seen;
        int rc;
        do_reset();
        wr_lat = 2;
        nx_req = 4'b0010;
        wait_issue(5, seen);
        wait_resp(20, rc);
        wr_lat = 20;
        nx_req = 4'b0100;
        wait_issue(5, seen);
        step();
        step();
        nx_reset = 1'b1;
        step();
        // Pointer was 2 before reset; all clients request, so only a cleared
        // pointer yields client 0.
        nx_reset = 1'b0;
        nx_req   = 4'b1111;
        nx_spur  = 1;
        step();
        tests_run++;
        if (busy !== 1'b0 || wr_reqcyc !== 1'b0 || cli_respcyc !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid got busy=%b req=%b resp=%b want 0 0 0000",
                     busy, wr_reqcyc, cli_respcyc);
        end
        nx_spur = 0;
        wait_issue(5, seen);
        tests_run++;
        if (grant_idx !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_grant got %0d want 0", grant_idx);
        end
        drain();
    endtask

    task automatic test_latch();
        bit seen;
        int rc;
        logic [63:0]     exp_addr;
        logic [0:LINE-1] exp_data;
`ifdef LATCH_DATA_EN
        exp_addr = 64'h2000;
        exp_data = PAT_A;
`else
        exp_addr = 64'h3000;
        exp_data = PAT_B;
`endif
        do_reset();
        wr_lat     = 6;
        nx_addr[0] = 64'h2000;
        nx_data[0] = PAT_A;
        nx_req     = 4'b0001;
        wait_issue(5, seen);
        nx_addr[0] = 64'h3000;
        nx_data[0] = PAT_B;
        wait_resp(20, rc);
        tests_run++;
        if (wr_addr !== exp_addr) begin
            tests_failed++;
            $display("FAIL latch_addr got %h want %h", wr_addr, exp_addr);
        end
        tests_run++;
        if (wr_data !== exp_data) begin
            tests_failed++;
            $display("FAIL latch_data got %h want %h", wr_data, exp_data);
        end
        drain();
    endtask

    task automatic test_random();
        logic [IDX_W-1:0] r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) nx_req = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 3) == 0) begin
                r = IDX_W'($urandom_range(0, N - 1));
                nx_addr[r] = {32'($urandom), 32'($urandom)};
                nx_data[r] = rand_line();
            end
            nx_spur  = ($urandom_range(0, 9) == 0);
            nx_reset = ($urandom_range(0, 99) == 0);
            wr_lat   = $urandom_range(1, 8);
            step();
        end
        nx_reset = 1'b0;
        drain();
    endtask

    initial begin
        reset      = 1'b1;
        cli_req    = '0;
        cli_addr   = '0;
        cli_data   = '0;
        wr_respcyc = 1'b0;
        nx_reset   = 1'b1;
        nx_req     = '0;
        nx_addr    = '0;
        nx_data    = '0;
        nx_spur    = 0;
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_drop_and_spurious();
        test_reset_mid();
        test_latch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no end of run by %0t want completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
